// File: rtl/audio_pkg.sv
// Shared definitions for the audio front-end blocks: default sample width, bar width
// and the saturating magnitude helper.
package audio_pkg;

  localparam int unsigned SAMPLE_DEPTH_DEFAULT = 16;
  localparam int unsigned BAR_WIDTH            = 8;

  // |s| clamped to 2^(depth-1)-1, so the most negative code still fits in depth-1 bits.
  function automatic logic [31:0] sat_mag(input logic signed [31:0] s,
                                          input int unsigned         depth);
    logic [31:0] lim;
    logic [31:0] m;
    lim = (32'd1 << (depth - 1)) - 32'd1;
    m   = (s < 0) ? 32'(-s) : 32'(s);
    return (m > lim) ? lim : m;
  endfunction

endpackage

// File: rtl/level_to_bar.sv
// Converts a level magnitude into an 8-segment thermometer bar using the bit length of the
// level, so each extra segment represents roughly a doubling (about 6 dB).
module level_to_bar
  import audio_pkg::*;
#(
  parameter int unsigned LEVEL_W = SAMPLE_DEPTH_DEFAULT - 1
) (
  input  logic [LEVEL_W-1:0]   level,
  output logic [BAR_WIDTH-1:0] bar
);

  // Bit lengths at or below this offset light no segment.
  localparam int Offset = int'(LEVEL_W) - int'(BAR_WIDTH);

  int bitlen;
  int n;

  always_comb begin
    bitlen = 0;
    for (int i = 0; i < int'(LEVEL_W); i++) begin
      if (level[i]) bitlen = i + 1;
    end
    n = bitlen - Offset;
    if (n < 0) n = 0;
    if (n > int'(BAR_WIDTH)) n = int'(BAR_WIDTH);
    bar = '0;
    for (int i = 0; i < int'(BAR_WIDTH); i++) begin
      bar[i] = (i < n);
    end
  end

endmodule

// File: rtl/audio_level_meter.sv
// Audio level meter: decaying peak hold plus windowed mean magnitude with a thermometer bar.
// All state advances only on qualified samples.
module audio_level_meter
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_DEPTH = SAMPLE_DEPTH_DEFAULT,
  parameter int unsigned WINDOW_LOG2  = 10,
  parameter int unsigned DECAY_PERIOD = 256,
  parameter int unsigned DECAY_SHIFT  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_valid,
  input  logic signed [SAMPLE_DEPTH-1:0] sample,
  output logic        [SAMPLE_DEPTH-2:0] peak,
  output logic        [SAMPLE_DEPTH-2:0] level,
  output logic                           level_valid,
  output logic        [BAR_WIDTH-1:0]    bar
);

  localparam int unsigned MagW = SAMPLE_DEPTH - 1;
  // Holds 2^WINDOW_LOG2 full-scale magnitudes without overflow.
  localparam int unsigned AccW = MagW + WINDOW_LOG2;
  localparam int unsigned WcW  = (WINDOW_LOG2 > 0) ? WINDOW_LOG2 : 1;
  localparam int unsigned DcW  = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  localparam logic [WcW-1:0] WinLast   = WcW'((1 << WINDOW_LOG2) - 1);
  localparam logic [DcW-1:0] DecayLast = DcW'(DECAY_PERIOD - 1);

  logic [MagW-1:0]      peak_q, peak_d, level_q, level_d, mag, cand;
  logic [AccW-1:0]      acc_q, acc_sum;
  logic [WcW-1:0]       win_cnt_q;
  logic [DcW-1:0]       decay_cnt_q;
  logic [BAR_WIDTH-1:0] bar_q, bar_d;
  logic                 level_valid_q, tick, win_last;

  always_comb begin
    mag      = MagW'(sat_mag(32'(sample), SAMPLE_DEPTH));
    tick     = (decay_cnt_q == DecayLast);
    win_last = (win_cnt_q == WinLast);
    cand     = tick ? (peak_q - (peak_q >> DECAY_SHIFT)) : peak_q;
    // Attack beats decay when both happen on the same sample.
    peak_d   = (mag > cand) ? mag : cand;
    acc_sum  = acc_q + AccW'(mag);
    level_d  = acc_sum[AccW-1:WINDOW_LOG2];
  end

  level_to_bar #(
    .LEVEL_W (MagW)
  ) u_level_to_bar (
    .level (level_d),
    .bar   (bar_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q        <= '0;
      level_q       <= '0;
      bar_q         <= '0;
      level_valid_q <= 1'b0;
      acc_q         <= '0;
      win_cnt_q     <= '0;
      decay_cnt_q   <= '0;
    end else begin
      level_valid_q <= sample_valid && win_last;
      if (sample_valid) begin
        peak_q      <= peak_d;
        decay_cnt_q <= tick ? '0 : decay_cnt_q + 1'b1;
        if (win_last) begin
          acc_q     <= '0;
          win_cnt_q <= '0;
          level_q   <= level_d;
          bar_q     <= bar_d;
        end else begin
          acc_q     <= acc_sum;
          win_cnt_q <= win_cnt_q + 1'b1;
        end
      end
    end
  end

  assign peak        = peak_q;
  assign level       = level_q;
  assign bar         = bar_q;
  assign level_valid = level_valid_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed bench for audio_level_meter with a window-result scoreboard.
module tb_audio_level_meter;

  logic               clk;
  logic               rst;
  logic               sample_valid;
  logic signed [15:0] sample;
  logic        [14:0] peak;
  logic        [14:0] level;
  logic               level_valid;
  logic        [7:0]  bar;

  typedef struct {
    logic [14:0] level;
    logic [7:0]  bar;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  audio_level_meter #(
    .SAMPLE_DEPTH (16),
    .WINDOW_LOG2  (2),
    .DECAY_PERIOD (4),
    .DECAY_SHIFT  (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .peak         (peak),
    .level        (level),
    .level_valid  (level_valid),
    .bar          (bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_peak"}, 32'(peak), 0);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_bar"}, 32'(bar), 0);
    check({tag, "_level_valid"}, 32'(level_valid), 0);
  endtask

  // Called at a negedge; returns at the negedge after the capturing posedge.
  task automatic send(input logic signed [15:0] s);
    sample       = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sample       = '0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [14:0] lvl, input logic [7:0] b);
    exp_t e;
    e.level = lvl;
    e.bar   = b;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every level_valid pulse must match the next queued window result.
  always @(negedge clk) begin
    if (level_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_level_valid", 32'(level_valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_level", 32'(level), 32'(e.level));
        check("sb_bar", 32'(bar), 32'(e.bar));
      end
    end
  end

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    repeat (2) @(negedge clk);
    check_zero("por");
    rst = 1'b0;
    @(negedge clk);

    // Basic window: mean of 100,200,300,400
    push_exp(15'd250, 8'h01);
    send(100);
    check("win_peak1", 32'(peak), 100);
    send(-200);
    send(300);
    check("win_lv_early", 32'(level_valid), 0);
    send(-400);
    check("win_lv_pulse", 32'(level_valid), 1);
    check("win_peak4", 32'(peak), 400);
    @(negedge clk);
    check("win_lv_drop", 32'(level_valid), 0);
    check("win_level_hold", 32'(level), 250);

    // Asynchronous reset mid-cycle, then held while samples arrive
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    repeat (4) send(5000);
    check_zero("rst_held");
    rst = 1'b0;
    @(negedge clk);

    // Saturation
    send(-32768);
    check("sat_peak", 32'(peak), 32767);
    push_exp(15'd32767, 8'hFF);
    repeat (3) send(-32768);
    check("sat_lv", 32'(level_valid), 1);
    check("sat_level", 32'(level), 32767);
    check("sat_peak_tick", 32'(peak), 32767);

    // Decay: 1000 then seven zeros
    pulse_rst();
    send(1000);
    check("decay_s1", 32'(peak), 1000);
    send(0);
    send(0);
    check("decay_s3", 32'(peak), 1000);
    push_exp(15'd250, 8'h01);
    send(0);
    check("decay_s4", 32'(peak), 500);
    push_exp(15'd0, 8'h00);
    repeat (3) send(0);
    check("decay_s7", 32'(peak), 500);
    send(0);
    check("decay_s8", 32'(peak), 250);

    // Attack vs decay on a tick sample
    pulse_rst();
    send(1000);
    send(0);
    send(0);
    push_exp(15'd400, 8'h03);
    send(600);
    check("attack_600", 32'(peak), 600);
    pulse_rst();
    send(1000);
    send(0);
    send(0);
    push_exp(15'd350, 8'h03);
    send(400);
    check("attack_400", 32'(peak), 500);

    // Mid-window reset discards partial window; gaps change nothing
    pulse_rst();
    send(1000);
    send(1000);
    check("mid_peak", 32'(peak), 1000);
    pulse_rst();
    push_exp(15'd8, 8'h00);
    for (int k = 0; k < 4; k++) begin
      send(8);
      if (k < 3) begin
        check("mid_lv_early", 32'(level_valid), 0);
        repeat (2) @(negedge clk);
        check("mid_gap_peak", 32'(peak), 8);
        check("mid_gap_level", 32'(level), 0);
        check("mid_gap_lv", 32'(level_valid), 0);
      end
    end
    check("mid_lv", 32'(level_valid), 1);
    check("mid_level", 32'(level), 8);
    check("mid_bar", 32'(bar), 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_level_meter.md
AUDIO_LEVEL_METER -- requirements
Module: audio_level_meter

Interface
REQ-001 SHALL have parameter SAMPLE_DEPTH, default 16: width of the signed input sample.
REQ-002 SHALL have parameter WINDOW_LOG2, default 10: the averaging window is 2^WINDOW_LOG2 valid samples.
REQ-003 SHALL have parameter DECAY_PERIOD, default 256: number of valid samples between peak decay ticks; legal range >= 1.
REQ-004 SHALL have parameter DECAY_SHIFT, default 4: per tick, peak decays by peak >> DECAY_SHIFT.
REQ-005 SHALL have port clk, input, 1 bit: system clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port sample_valid, input, 1 bit: qualifies sample for exactly one clk cycle.
REQ-008 SHALL have port sample, input, SAMPLE_DEPTH bits, signed: PCM sample from the PDM microphone decimator.
REQ-009 SHALL have port peak, output, SAMPLE_DEPTH-1 bits: decaying peak magnitude.
REQ-010 SHALL have port level, output, SAMPLE_DEPTH-1 bits: mean magnitude of the last completed window.
REQ-011 SHALL have port level_valid, output, 1 bit: one-cycle pulse when level and bar update.
REQ-012 SHALL have port bar, output, 8 bits: thermometer code derived from level.

Function
REQ-013 All state SHALL change only on cycles where sample_valid=1; otherwise it holds.
REQ-014 mag SHALL be |sample|, saturated to 2^(SAMPLE_DEPTH-1)-1 (for example, -32768 gives 32767).
REQ-015 decay_cnt SHALL count valid samples 0..DECAY_PERIOD-1 and wrap to 0; a tick occurs on the valid sample at which decay_cnt = DECAY_PERIOD-1.
REQ-016 On a valid sample, the candidate value SHALL be peak - (peak >> DECAY_SHIFT) on a tick and peak otherwise; peak <= max(mag, candidate).
REQ-017 The attack in REQ-016 SHALL win over the decay when a tick and a larger mag occur together.
REQ-018 peak SHALL update on the clk edge following the cycle that carries sample_valid (1-cycle latency).
REQ-019 The accumulator SHALL be SAMPLE_DEPTH-1+WINDOW_LOG2 bits wide and SHALL never overflow.
REQ-020 win_cnt SHALL count valid samples 0..2^WINDOW_LOG2-1 and wrap to 0.
REQ-021 On each valid sample, the accumulator SHALL add mag.
REQ-022 On the last sample of a window (win_cnt at maximum): level <= (acc + mag) >> WINDOW_LOG2, acc <= 0, and level_valid = 1 in the following cycle only.
REQ-023 bar SHALL update in the same cycle as level.
REQ-024 For bar, n = max(0, bitlen(new level) - (SAMPLE_DEPTH-1-8)), where bitlen(0) = 0; bar SHALL have its n LSBs set (0..8).
REQ-025 level_valid SHALL be 0 in every other cycle; back-to-back valid samples at full clk rate SHALL be supported.

Reset
REQ-026 While rst=1: peak, level, bar, level_valid, acc, win_cnt and decay_cnt SHALL be 0.
REQ-027 Reset mid-window SHALL discard the partial window; the first window after release SHALL start at win_cnt = 0.

Structure
REQ-028 A shared package audio_pkg SHALL hold SAMPLE_DEPTH_DEFAULT, BAR_WIDTH=8, and the magnitude-saturation function reused by audio blocks.
REQ-029 A combinational sub-module level_to_bar SHALL perform the bitlen and thermometer conversion; all other logic SHALL stay in audio_level_meter.

Verification (bench params: SAMPLE_DEPTH=16, WINDOW_LOG2=2, DECAY_PERIOD=4, DECAY_SHIFT=1)
REQ-030 Reset: assert rst asynchronously mid-cycle -> all outputs read 0 immediately; hold rst with valid samples applied -> outputs stay 0.
REQ-031 Window: samples 100, -200, 300, -400 -> level = 250, bar = 8'b00000001, level_valid high exactly 1 cycle after the 4th sample.
REQ-032 Saturation: a single sample -32768 -> peak = 32767 next cycle; a full window of -32768 -> level = 32767, bar = 8'hFF.
REQ-033 Decay: sample 1000 as decay_cnt 0, then seven 0 samples -> peak = 1000 until the 4th sample, 500 after the 4th, 250 after the 8th.
REQ-034 Attack vs decay: peak = 1000 and a tick sample with mag 600 -> peak = 600; with mag 400 -> peak = 500.
REQ-035 Mid-window reset: two samples of 1000, pulse rst, then four samples of 8 -> level = 8, level_valid only after the 4th post-reset sample; gaps in sample_valid change nothing.
